// File: rtl/tlu_trigger_logic.sv
// TLU trigger decision: coincidence, veto/prescale/busy qualification, ID and time stamping, record queue.
// Optional prescaler compiled in with `define TLU_TRIGGER_PRESCALE_EN.
module tlu_trigger_logic #(
  parameter int N_IN          = 4,
  parameter int N_OUT         = 6,
  parameter int LE_WIDTH      = 8,
  parameter int TRIG_ID_WIDTH = 32,
  parameter int TS_WIDTH      = 64,
  parameter int REC_DEPTH     = 4
) (
  input  logic                                      SYS_CLK,
  input  logic                                      SYS_RST_N,
  input  logic                                      START,
  input  logic [N_IN-1:0]                           CONF_EN_INPUT,
  input  logic [1:0]                                CONF_MODE,
  input  logic [3:0]                                CONF_MAJORITY,
  input  logic [LE_WIDTH-1:0]                       CONF_MAX_LE_DISTANCE,
  input  logic [15:0]                               CONF_PRESCALE,
  input  logic [N_OUT-1:0]                          CONF_EN_OUTPUT,
  input  logic                                      TEST_PULSE,
  input  logic                                      VETO,
  input  logic [N_IN-1:0]                           IN_VALID,
  input  logic [N_IN*LE_WIDTH-1:0]                  IN_LE_REL,
  input  logic [N_OUT-1:0]                          OUT_READY,
  output logic                                      TRIG,
  output logic [LE_WIDTH-1:0]                       TRIG_LE,
  output logic [TRIG_ID_WIDTH-1:0]                  TRIG_ID,
  output logic [TS_WIDTH-1:0]                       TIME_STAMP,
  output logic                                      REC_VALID,
  input  logic                                      REC_READY,
  output logic [TRIG_ID_WIDTH+TS_WIDTH+N_IN*LE_WIDTH-1:0] REC_DATA,
  output logic [31:0]                               SKIP_CNT,
  output logic [15:0]                               VETO_CNT,
  output logic [7:0]                                LOST_CNT
);
  localparam int LES_W = N_IN * LE_WIDTH;
  localparam int REC_W = TRIG_ID_WIDTH + TS_WIDTH + LES_W;
  localparam int PTR_W = $clog2(REC_DEPTH);

  logic [N_IN-1:0]     active;
  logic [LES_W-1:0]    le_masked;
  logic [LE_WIDTH-1:0] le_max, le_min, le_span;
  logic [3:0]          hit_cnt;
  logic                coinc, gen_d;

  assign active = IN_VALID & CONF_EN_INPUT;

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_mask
      assign le_masked[gi*LE_WIDTH +: LE_WIDTH] =
        CONF_EN_INPUT[gi] ? IN_LE_REL[gi*LE_WIDTH +: LE_WIDTH] : '0;
    end
  endgenerate

  always_comb begin
    le_max  = '0;
    le_min  = '1;
    hit_cnt = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (active[i]) begin
        if (IN_LE_REL[i*LE_WIDTH +: LE_WIDTH] > le_max) le_max = IN_LE_REL[i*LE_WIDTH +: LE_WIDTH];
        if (IN_LE_REL[i*LE_WIDTH +: LE_WIDTH] < le_min) le_min = IN_LE_REL[i*LE_WIDTH +: LE_WIDTH];
        hit_cnt = hit_cnt + 4'd1;
      end
    end
    le_span = (active != '0) ? le_max - le_min : '0;
    case (CONF_MODE)
      2'd0:    coinc = (CONF_EN_INPUT != '0) && (active == CONF_EN_INPUT);
      2'd1:    coinc = (active != '0);
      2'd2:    coinc = (CONF_MAJORITY != 4'd0) && (hit_cnt >= CONF_MAJORITY);
      default: coinc = 1'b0;
    endcase
    gen_d = (coinc && (le_span < CONF_MAX_LE_DISTANCE)) || TEST_PULSE;
  end

  // GEN and its hit data are registered so a candidate is judged one cycle after GEN rises
  logic                     gen_q, gen_prev_q, gen_prev_d, cand_test_q;
  logic [LE_WIDTH-1:0]      cand_max_q;
  logic [LES_W-1:0]         cand_le_q;
  logic [TRIG_ID_WIDTH-1:0] trig_id_q, trig_id_d;
  logic [TS_WIDTH-1:0]      ts_q, ts_d;
  logic [31:0]              skip_cnt_q, skip_cnt_d;
  logic [15:0]              veto_cnt_q, veto_cnt_d;
  logic [7:0]               lost_cnt_q, lost_cnt_d;
  logic [PTR_W:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                     cand, pass_pre, outs_ok, accept, trig;
  logic                     rec_empty, rec_full, rec_pop, rec_push;
`ifdef TLU_TRIGGER_PRESCALE_EN
  logic [15:0]              prescale_q, prescale_d;
`else
  logic                     unused_prescale;
  assign unused_prescale = ^CONF_PRESCALE;
`endif

  always_comb begin
    gen_prev_d = gen_q;
    cand       = gen_q && !gen_prev_q && !START;
`ifdef TLU_TRIGGER_PRESCALE_EN
    pass_pre   = cand_test_q || (prescale_q == CONF_PRESCALE);
    prescale_d = prescale_q;
    if (START)
      prescale_d = '0;
    else if (cand && !VETO && !cand_test_q)
      prescale_d = (prescale_q == CONF_PRESCALE) ? 16'd0 : prescale_q + 16'd1;
`else
    pass_pre   = 1'b1;
`endif
    outs_ok   = &(OUT_READY | ~CONF_EN_OUTPUT);
    accept    = cand && !VETO && pass_pre;
    trig      = accept && outs_ok;

    // Pop is honoured before push, so a full queue being drained still accepts a record
    rec_empty = (wr_ptr_q == rd_ptr_q);
    rec_full  = ((wr_ptr_q - rd_ptr_q) == (PTR_W+1)'(REC_DEPTH));
    rec_pop   = !rec_empty && REC_READY;
    rec_push  = trig && (!rec_full || rec_pop);
    wr_ptr_d  = wr_ptr_q + (PTR_W+1)'(rec_push);
    rd_ptr_d  = rd_ptr_q + (PTR_W+1)'(rec_pop);

    ts_d       = START ? TS_WIDTH'(1) : ((ts_q == '1) ? ts_q : ts_q + TS_WIDTH'(1));
    trig_id_d  = START ? '0 : trig_id_q + TRIG_ID_WIDTH'(trig);
    skip_cnt_d = START ? '0 : skip_cnt_q + 32'(accept && !outs_ok);
    veto_cnt_d = START ? '0 :
                 ((cand && VETO && veto_cnt_q != '1) ? veto_cnt_q + 16'd1 : veto_cnt_q);
    lost_cnt_d = (trig && !rec_push && lost_cnt_q != '1) ? lost_cnt_q + 8'd1 : lost_cnt_q;
  end

  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      gen_q       <= 1'b0;
      gen_prev_q  <= 1'b0;
      cand_test_q <= 1'b0;
      cand_max_q  <= '0;
      cand_le_q   <= '0;
      trig_id_q   <= '0;
      ts_q        <= TS_WIDTH'(1);
      skip_cnt_q  <= '0;
      veto_cnt_q  <= '0;
      lost_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
`ifdef TLU_TRIGGER_PRESCALE_EN
      prescale_q  <= '0;
`endif
    end else begin
      gen_q       <= gen_d;
      gen_prev_q  <= gen_prev_d;
      cand_test_q <= TEST_PULSE;
      cand_max_q  <= le_max;
      cand_le_q   <= le_masked;
      trig_id_q   <= trig_id_d;
      ts_q        <= ts_d;
      skip_cnt_q  <= skip_cnt_d;
      veto_cnt_q  <= veto_cnt_d;
      lost_cnt_q  <= lost_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
`ifdef TLU_TRIGGER_PRESCALE_EN
      prescale_q  <= prescale_d;
`endif
    end
  end

  logic [REC_W-1:0] rec_mem [REC_DEPTH];

  always_ff @(posedge SYS_CLK) begin
    if (rec_push) rec_mem[wr_ptr_q[PTR_W-1:0]] <= {trig_id_q, ts_q, cand_le_q};
  end

  assign TRIG       = trig;
  assign TRIG_LE    = trig ? cand_max_q : '0;
  assign TRIG_ID    = trig_id_q;
  assign TIME_STAMP = ts_q;
  assign REC_VALID  = !rec_empty;
  assign REC_DATA   = rec_empty ? '0 : rec_mem[rd_ptr_q[PTR_W-1:0]];
  assign SKIP_CNT   = skip_cnt_q;
  assign VETO_CNT   = veto_cnt_q;
  assign LOST_CNT   = lost_cnt_q;

endmodule

// File: tb/tb_tlu_trigger_logic.sv
// Scoreboard bench for tlu_trigger_logic: expected triggers/records queued at stimulus, compared at DUT output.
`timescale 1ns/1ps
module tb_tlu_trigger_logic;
  localparam int N_IN = 4, N_OUT = 6, LE_WIDTH = 8, TRIG_ID_WIDTH = 32, TS_WIDTH = 64, REC_DEPTH = 4;
  localparam int LES_W = N_IN * LE_WIDTH;
  localparam int REC_W = TRIG_ID_WIDTH + TS_WIDTH + LES_W;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     start = 1'b0;
  logic [N_IN-1:0]          conf_en_input;
  logic [1:0]               conf_mode;
  logic [3:0]               conf_majority;
  logic [LE_WIDTH-1:0]      conf_max_le_distance;
  logic [15:0]              conf_prescale;
  logic [N_OUT-1:0]         conf_en_output;
  logic                     test_pulse = 1'b0;
  logic                     veto = 1'b0;
  logic [N_IN-1:0]          in_valid = '0;
  logic [LES_W-1:0]         in_le_rel = '0;
  logic [N_OUT-1:0]         out_ready;
  logic                     trig;
  logic [LE_WIDTH-1:0]      trig_le;
  logic [TRIG_ID_WIDTH-1:0] trig_id;
  logic [TS_WIDTH-1:0]      time_stamp;
  logic                     rec_valid;
  logic                     rec_ready;
  logic [REC_W-1:0]         rec_data;
  logic [31:0]              skip_cnt;
  logic [15:0]              veto_cnt;
  logic [7:0]               lost_cnt;

  tlu_trigger_logic #(
    .N_IN(N_IN), .N_OUT(N_OUT), .LE_WIDTH(LE_WIDTH),
    .TRIG_ID_WIDTH(TRIG_ID_WIDTH), .TS_WIDTH(TS_WIDTH), .REC_DEPTH(REC_DEPTH)
  ) dut (
    .SYS_CLK(clk), .SYS_RST_N(rst_n), .START(start),
    .CONF_EN_INPUT(conf_en_input), .CONF_MODE(conf_mode), .CONF_MAJORITY(conf_majority),
    .CONF_MAX_LE_DISTANCE(conf_max_le_distance), .CONF_PRESCALE(conf_prescale),
    .CONF_EN_OUTPUT(conf_en_output), .TEST_PULSE(test_pulse), .VETO(veto),
    .IN_VALID(in_valid), .IN_LE_REL(in_le_rel), .OUT_READY(out_ready),
    .TRIG(trig), .TRIG_LE(trig_le), .TRIG_ID(trig_id), .TIME_STAMP(time_stamp),
    .REC_VALID(rec_valid), .REC_READY(rec_ready), .REC_DATA(rec_data),
    .SKIP_CNT(skip_cnt), .VETO_CNT(veto_cnt), .LOST_CNT(lost_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] id; logic [7:0] le; } trig_exp_t;
  typedef struct { logic [31:0] id; logic [31:0] les; } rec_exp_t;

  trig_exp_t   exp_trig[$];
  rec_exp_t    exp_rec[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_id = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  trig_exp_t mon_t;
  rec_exp_t  mon_r;

  always @(negedge clk) begin
    if (rst_n) begin
      if (trig) begin
        if (exp_trig.size() == 0) check("unexpected_trig", 64'd1, 64'd0);
        else begin
          mon_t = exp_trig.pop_front();
          check("trig_id", 64'(trig_id), 64'(mon_t.id));
          check("trig_le", 64'(trig_le), 64'(mon_t.le));
          $display("trig id=%0d le=%0d", trig_id, trig_le);
        end
      end
      if (rec_valid && rec_ready) begin
        if (exp_rec.size() == 0) check("unexpected_rec", 64'd1, 64'd0);
        else begin
          mon_r = exp_rec.pop_front();
          check("rec_id", 64'(rec_data[REC_W-1 -: TRIG_ID_WIDTH]), 64'(mon_r.id));
          check("rec_le", 64'(rec_data[LES_W-1:0]), 64'(mon_r.les));
          $display("rec id=%0d les=%08h", rec_data[REC_W-1 -: TRIG_ID_WIDTH], rec_data[LES_W-1:0]);
        end
      end
    end
  end

  // One hit for a single cycle (cycle n); veto/start are applied in the candidate cycle n+1
  task automatic hit(input logic [3:0] valid, input logic [31:0] les, input bit tp,
                     input bit vt, input bit st, input bit want);
    trig_exp_t te;
    rec_exp_t  re;
    logic [7:0]  mx;
    logic [31:0] rl;
    mx = '0;
    rl = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (valid[i] && conf_en_input[i] && les[i*8 +: 8] > mx) mx = les[i*8 +: 8];
      if (conf_en_input[i]) rl[i*8 +: 8] = les[i*8 +: 8];
    end
    if (want) begin
      te.id = exp_id; te.le = mx;
      re.id = exp_id; re.les = rl;
      exp_trig.push_back(te);
      exp_rec.push_back(re);
      exp_id++;
    end
    @(posedge clk); #1;
    in_valid = valid; in_le_rel = les; test_pulse = tp;
    @(posedge clk); #1;
    in_valid = '0; in_le_rel = '0; test_pulse = 1'b0; veto = vt; start = st;
    @(negedge clk);
    check("trig_cycle", 64'(trig), 64'(want));
    @(posedge clk); #1;
    veto = 1'b0; start = 1'b0;
    @(negedge clk);
    check("trig_one_shot", 64'(trig), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    bit want;
    conf_en_input = 4'b0011; conf_mode = 2'd0; conf_majority = 4'd0;
    conf_max_le_distance = 8'd4; conf_prescale = 16'd0;
    conf_en_output = 6'h3F; out_ready = 6'h3F; rec_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_trig", 64'(trig), 64'd0);
    check("rst_ts", time_stamp, 64'd1);
    check("rst_id", 64'(trig_id), 64'd0);
    check("rst_rec_valid", 64'(rec_valid), 64'd0);
    check("rst_cnts", {skip_cnt, veto_cnt, lost_cnt}, 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk); check("ts_start", time_stamp, 64'd1);
    @(negedge clk); check("ts_count", time_stamp, 64'd2);

    // AND of ch0/ch1: ch2 is ignored for max and masked in the record
    hit(4'b1111, {8'd3, 8'd9, 8'd7, 8'd5}, 0, 0, 0, 1);
    conf_max_le_distance = 8'd2;
    hit(4'b1111, {8'd3, 8'd9, 8'd7, 8'd5}, 0, 0, 0, 0);
    check("window_skip", 64'(skip_cnt), 64'd0);
    check("window_veto", 64'(veto_cnt), 64'd0);
    conf_max_le_distance = 8'hFF;

    conf_mode = 2'd2; conf_majority = 4'd3; conf_en_input = 4'b1111;
    hit(4'b0111, {8'd40, 8'd30, 8'd20, 8'd10}, 0, 0, 0, 1);
    hit(4'b0011, {8'd40, 8'd30, 8'd20, 8'd10}, 0, 0, 0, 0);

    conf_mode = 2'd1; conf_en_input = 4'b0001; conf_prescale = 16'd2;
    for (int i = 0; i < 9; i++) begin
`ifdef TLU_TRIGGER_PRESCALE_EN
      want = ((i % 3) == 2);
`else
      want = 1'b1;
`endif
      hit(4'b0001, 32'(i + 1), 0, 0, 0, want);
    end
    conf_prescale = 16'd0;

    conf_en_output = 6'b000001; out_ready = 6'b111110;
    hit(4'b0001, 32'd12, 0, 0, 0, 0);
    check("skip_busy", 64'(skip_cnt), 64'd1);
    out_ready = 6'b011111;
    hit(4'b0001, 32'd13, 0, 0, 0, 1);
    conf_en_output = 6'h3F; out_ready = 6'h3F;

    rec_ready = 1'b0;
    for (int i = 0; i < 5; i++) hit(4'b0001, 32'(20 + i), 0, 0, 0, 1);
    void'(exp_rec.pop_back());
    check("lost_full", 64'(lost_cnt), 64'd1);
    check("rec_held", 64'(rec_valid), 64'd1);
    rec_ready = 1'b1;
    for (int i = 0; i < 20 && rec_valid; i++) @(negedge clk);
    check("drain_done", 64'(rec_valid), 64'd0);
    check("rec_left", 64'(exp_rec.size()), 64'd0);

    hit(4'b0001, 32'd30, 0, 1, 0, 0);
    check("veto_cnt", 64'(veto_cnt), 64'd1);

    conf_mode = 2'd3;
    hit(4'b0000, 32'd0, 1, 0, 0, 1);
    conf_mode = 2'd1;

    hit(4'b0001, 32'd5, 0, 0, 1, 0);
    exp_id = '0;
    check("start_id", 64'(trig_id), 64'd0);
    check("start_cnts", {skip_cnt, veto_cnt}, 64'd0);
    check("start_lost", 64'(lost_cnt), 64'd1);
    hit(4'b0001, 32'd6, 0, 0, 0, 1);

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("trig_left", 64'(exp_trig.size()), 64'd0);
    check("rec_left_end", 64'(exp_rec.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
